config_streamer: RTL and testbench
==================================

# config_streamer

Serialises host-supplied reconfiguration frames onto the shared configId/configData broadcast bus read by every instrumentation block (filter-reduce units, vector scalar reduce, etc.). It is the transmitting end of that bus: it stops tracing and drains the trace pipeline. Each frame is buffered whole before transmission, because receivers advance their byte counters on every cycle their ID is present. Each frame is then emitted as one contiguous burst. The block sits between the host/JTAG byte link and the tracing chain.

## Interface
- MAX_PAYLOAD, 256: payload buffer depth in bytes; largest frame that can be emitted.
- DRAIN_CYCLES, 4: cycles hold_trace is asserted before tracing drops; at least the deepest chain latency.
- IDLE_CONFIG_ID, 8'hFF: bus value when no block is addressed; also the END-of-reconfiguration command.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- host_valid  in  1  host byte valid.
- host_ready  out  1  streamer accepts host_data this cycle (transfer = valid & ready).
- host_data  in  8  frame byte.
- tracing  out  1  1 = trace mode; 0 = chain in reconfiguration.
- hold_trace  out  1  request to the trace source to stop issuing valid vectors.
- configId  out  8  target block ID on the broadcast bus.
- configData  out  8  payload byte on the broadcast bus.
- busy  out  1  any state other than TRACE.
- err  out  1  sticky: oversize frame seen; cleared only by reset.

## Operation
- Frame format: ID byte; LEN_H; LEN_L (16-bit length L, MSB first); L payload bytes. An ID byte equal to IDLE_CONFIG_ID is a single-byte END command with no length field.
- States: TRACE, DRAIN, HDR_ID, LEN_H, LEN_L, CAPTURE, EMIT, GAP, DISCARD.
- TRACE: host_ready=1. A non-IDLE ID byte is latched, hold_trace<=1, drain counter loaded, and the FSM goes to DRAIN. An END byte in TRACE is consumed with no effect.
- DRAIN: host_ready=0. Counts DRAIN_CYCLES, then tracing<=0 and the FSM goes to LEN_H.
- HDR_ID (reconfiguration mode, tracing=0): host_ready=1.
  - Non-IDLE ID: latch it and go to LEN_H.
  - END: go to GAP with a resume flag set.
- LEN_H/LEN_L: host_ready=1; each accepts one byte into L.
  - L > MAX_PAYLOAD: err<=1, go to DISCARD.
  - L == 0: go to GAP.
  - Otherwise go to CAPTURE.
- CAPTURE: host_ready=1 while captured count < L; bytes are written to the buffer at index count. When count reaches L, go to EMIT.
- EMIT: host_ready=0. For exactly L consecutive cycles: configId=latched ID, configData=buf[k], k=0..L-1 in arrival order. There are no bubbles.
- GAP: one cycle with configId=IDLE_CONFIG_ID, configData=0. This resets receiver byte counters.
  - Then go to HDR_ID.
  - If the resume flag is set: tracing<=1, hold_trace<=0, go to TRACE.
- DISCARD: host_ready=1. Consumes L bytes without storing them, then goes to HDR_ID. No GAP, and the bus stays idle.
- Outside EMIT, configId=IDLE_CONFIG_ID and configData=0.
- Counters are $clog2(MAX_PAYLOAD+1) bits for count/k; L is held at 16 bits.

## Timing
- Reset values: tracing=1, hold_trace=0, configId=IDLE_CONFIG_ID, configData=0, busy=0, err=0, host_ready=1, state TRACE.
- All outputs are registered.
- tracing falls DRAIN_CYCLES+1 cycles after the ID byte is accepted in TRACE. hold_trace rises 1 cycle after that acceptance.
- The first EMIT byte appears on the bus 1 cycle after the last payload byte is accepted.
- The first byte of the next frame is accepted no earlier than the cycle after GAP.
- After an END byte is accepted: GAP appears next cycle, and tracing=1 / hold_trace=0 the cycle after that.
- Host stalls (host_valid=0) in any header or CAPTURE state are legal and never affect the bus.
- Reset mid-frame: immediate return to reset values. The partial frame is lost. Buffer contents are don't-care.

## Test plan
- From reset, send {8'h03, 8'h00, 8'h02, 8'hAA, 8'h55, 8'hFF}:
  - hold_trace rises and tracing falls after 4 more cycles.
  - Bus shows (03,AA),(03,55) on consecutive cycles, then (FF,00).
  - After END: tracing=1, hold_trace=0.
- Same frame with host_valid toggling 0/1 every cycle during payload: identical contiguous 2-cycle burst; no configId=03 cycle without data.
- Two frames back-to-back (ID 1, L=1, 8'h11; ID 2, L=3, 8'h21..8'h23), then END: bursts separated by exactly one IDLE cycle; tracing stays 0 between frames.
- Frame with ID 5, L=0x0101 (> MAX_PAYLOAD=256):
  - err=1; 257 bytes consumed; configId never equals 5.
  - A following valid frame still emits correctly.
- Assert reset during EMIT of a 4-byte frame after the 2nd byte: next cycle configId=FF, tracing=1, busy=0, host_ready=1.
- END byte sent while in TRACE: consumed; tracing and hold_trace unchanged; bus stays idle.

Source files
------------

// File: rtl/config_streamer.sv
// config_streamer: buffers host reconfiguration frames and replays each
// one as a contiguous configId/configData burst on the broadcast bus.
module config_streamer #(
  parameter int          MAX_PAYLOAD    = 256,
  parameter int          DRAIN_CYCLES   = 4,
  parameter logic [7:0]  IDLE_CONFIG_ID = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic [7:0] host_data,
  output logic       tracing,
  output logic       hold_trace,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_TRACE,
    S_DRAIN,
    S_HDR_ID,
    S_LEN_H,
    S_LEN_L,
    S_CAPTURE,
    S_EMIT,
    S_GAP,
    S_DISCARD
  } state_t;

  state_t          state;
  logic [7:0]      id_q;
  logic [15:0]     len_q;
  logic [15:0]     len_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   k;
  logic [AW-1:0]   k_nxt;
  logic [DW-1:0]   drain_cnt;
  logic            resume;
  logic            xfer;
  logic [7:0]      mem [MAX_PAYLOAD];

  assign xfer    = host_valid & host_ready;
  assign len_nxt = {len_q[15:8], host_data};
  assign k_nxt   = k[AW-1:0] + AW'(1);

  always_ff @(posedge clk) begin
    if (state == S_CAPTURE && xfer)
      mem[cnt[AW-1:0]] <= host_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_TRACE;
      tracing    <= 1'b1;
      hold_trace <= 1'b0;
      configId   <= IDLE_CONFIG_ID;
      configData <= 8'h00;
      busy       <= 1'b0;
      err        <= 1'b0;
      host_ready <= 1'b1;
      id_q       <= 8'h00;
      len_q      <= 16'h0000;
      cnt        <= '0;
      k          <= '0;
      drain_cnt  <= '0;
      resume     <= 1'b0;
    end else begin
      unique case (state)
        S_TRACE: begin
          if (xfer && host_data != IDLE_CONFIG_ID) begin
            id_q       <= host_data;
            hold_trace <= 1'b1;
            busy       <= 1'b1;
            host_ready <= 1'b0;
            drain_cnt  <= DW'(DRAIN_CYCLES - 1);
            state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            tracing    <= 1'b0;
            host_ready <= 1'b1;
            state      <= S_LEN_H;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_HDR_ID: begin
          if (xfer) begin
            if (host_data == IDLE_CONFIG_ID) begin
              resume     <= 1'b1;
              host_ready <= 1'b0;
              state      <= S_GAP;
            end else begin
              id_q  <= host_data;
              state <= S_LEN_H;
            end
          end
        end
        S_LEN_H: begin
          if (xfer) begin
            len_q[15:8] <= host_data;
            state       <= S_LEN_L;
          end
        end
        S_LEN_L: begin
          if (xfer) begin
            len_q <= len_nxt;
            cnt   <= '0;
            if (len_nxt > 16'(MAX_PAYLOAD)) begin
              err   <= 1'b1;
              state <= S_DISCARD;
            end else if (len_nxt == 16'd0) begin
              host_ready <= 1'b0;
              state      <= S_GAP;
            end else begin
              state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (xfer) begin
            cnt <= cnt + CW'(1);
            if (16'(cnt) + 16'd1 == len_q) begin
              // a 1-byte frame has not reached the buffer yet
              host_ready <= 1'b0;
              configId   <= id_q;
              configData <= (cnt == '0) ? host_data : mem[0];
              k          <= '0;
              state      <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (16'(k) + 16'd1 == len_q) begin
            configId   <= IDLE_CONFIG_ID;
            configData <= 8'h00;
            state      <= S_GAP;
          end else begin
            k          <= k + CW'(1);
            configData <= mem[k_nxt];
          end
        end
        S_GAP: begin
          host_ready <= 1'b1;
          if (resume) begin
            resume     <= 1'b0;
            tracing    <= 1'b1;
            hold_trace <= 1'b0;
            busy       <= 1'b0;
            state      <= S_TRACE;
          end else begin
            state <= S_HDR_ID;
          end
        end
        S_DISCARD: begin
          if (xfer) begin
            len_q <= len_q - 16'd1;
            if (len_q == 16'd1)
              state <= S_HDR_ID;
          end
        end
        default: state <= S_TRACE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_streamer.sv
// tb_config_streamer: directed, table-driven and random frame traffic
// checked against a frame-level model of the expected bus bursts.
module tb_config_streamer;

  localparam int         MAXP = 256;
  localparam int         DRN  = 4;
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] host_data;
  logic       tracing;
  logic       hold_trace;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  config_streamer #(
    .MAX_PAYLOAD(MAXP),
    .DRAIN_CYCLES(DRN),
    .IDLE_CONFIG_ID(IDLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_data(host_data),
    .tracing(tracing),
    .hold_trace(hold_trace),
    .configId(configId),
    .configData(configData),
    .busy(busy),
    .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // expected bursts: one id/len per frame, data bytes in bus order
  logic [7:0] exp_id_q[$];
  int         exp_len_q[$];
  logic [7:0] exp_dat_q[$];
  bit         exp_err;
  logic [7:0] pl[$];

  bit         mon_en;
  int         run;
  logic [7:0] run_id;

  always @(negedge clk) begin
    if (!mon_en || reset) begin
      run = 0;
    end else if (configId != IDLE) begin
      if (run == 0) run_id = configId;
      else chk("burst_id_steady", configId, run_id);
      run++;
      if (exp_dat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bus_byte actual=%0h_%0h required=idle",
                 configId, configData);
      end else begin
        chk("bus_data", configData, exp_dat_q.pop_front());
      end
    end else begin
      chk("idle_data_zero", configData, 0);
      if (run > 0) begin
        if (exp_id_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_burst actual=%0h required=none", run_id);
        end else begin
          chk("burst_id", run_id, exp_id_q.pop_front());
          chk("burst_len", run, exp_len_q.pop_front());
        end
        run = 0;
      end
    end
  end

  function automatic void expect_frame(input logic [7:0] id, input int len);
    if (len > MAXP) begin
      exp_err = 1'b1;
    end else if (len > 0) begin
      exp_id_q.push_back(id);
      exp_len_q.push_back(len);
      foreach (pl[i]) exp_dat_q.push_back(pl[i]);
    end
  endfunction

  function automatic void fill_pl(input logic [7:0] id, input int len,
                                  input bit rnd);
    pl.delete();
    for (int i = 0; i < len; i++)
      pl.push_back(rnd ? 8'($urandom) : {id[3:0], 4'h0} + 8'(i + 1));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    bit ok;
    ok = 1'b0;
    host_valid = 1'b0;
    tick(gaps);
    host_valid = 1'b1;
    host_data  = b;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = host_ready;
      @(posedge clk);
      #1;
    end
    host_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_ready required=ready byte=%0h", b);
    end
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // mode: 0 no stalls, 1 valid toggles, 2 random stalls
  task automatic send_frame(input logic [7:0] id, input int len,
                            input int mode, input bit rec);
    logic [15:0] l16;
    l16 = 16'(len);
    if (rec) expect_frame(id, len);
    send_byte(id, 0);
    send_byte(l16[15:8], gap_of(mode));
    send_byte(l16[7:0], gap_of(mode));
    foreach (pl[i]) send_byte(pl[i], gap_of(mode));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    tick(2);
    reset  = 1'b0;
    exp_id_q.delete();
    exp_len_q.delete();
    exp_dat_q.delete();
    exp_err = 1'b0;
    tick(1);
    mon_en = 1'b1;
  endtask

  typedef struct {
    logic [7:0] id;
    int         len;
    int         mode;
    bit         exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h01, 1,   0, 1'b0};
    tbl[1] = '{8'h02, 3,   0, 1'b0};
    tbl[2] = '{8'h07, 0,   0, 1'b0};
    tbl[3] = '{8'h05, 257, 0, 1'b1};
    tbl[4] = '{8'h09, 256, 2, 1'b1};
    tbl[5] = '{8'h0A, 2,   1, 1'b1};

    reset      = 1'b1;
    host_valid = 1'b0;
    host_data  = 8'h00;
    mon_en     = 1'b0;
    exp_err    = 1'b0;
    tick(3);
    chk("rst_tracing", tracing, 1);
    chk("rst_hold", hold_trace, 0);
    chk("rst_id", configId, IDLE);
    chk("rst_data", configData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", host_ready, 1);
    reset = 1'b0;
    tick(1);
    mon_en = 1'b1;

    // basic frame from trace mode, cycle-exact
    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'h55);
    expect_frame(8'h03, 2);
    send_byte(8'h03, 0);
    chk("a_hold_rise", hold_trace, 1);
    chk("a_busy", busy, 1);
    chk("a_ready_drain", host_ready, 0);
    tick(DRN - 1);
    chk("a_tracing_late", tracing, 1);
    tick(1);
    chk("a_tracing_fall", tracing, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    chk("a_emit0", {configId, configData}, 16'h03AA);
    tick(1);
    chk("a_emit1", {configId, configData}, 16'h0355);
    tick(1);
    chk("a_gap", {configId, configData}, 16'hFF00);
    tick(1);
    send_byte(IDLE, 0);
    chk("a_end_gap", configId, IDLE);
    chk("a_end_still_recfg", tracing, 0);
    tick(1);
    chk("a_resume_tracing", tracing, 1);
    chk("a_resume_hold", hold_trace, 0);
    chk("a_resume_busy", busy, 0);
    chk("a_resume_ready", host_ready, 1);

    // same frame with host_valid toggling during the payload
    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'h55);
    send_frame(8'h03, 2, 1, 1'b1);
    chk("b_emit0", {configId, configData}, 16'h03AA);
    tick(1);
    chk("b_emit1", {configId, configData}, 16'h0355);
    tick(1);
    chk("b_gap", {configId, configData}, 16'hFF00);
    tick(1);
    send_byte(IDLE, 0);
    tick(2);
    chk("b_tracing", tracing, 1);

    // table: one reconfiguration session, frames back-to-back
    foreach (tbl[i]) begin
      fill_pl(tbl[i].id, tbl[i].len, 1'b0);
      send_frame(tbl[i].id, tbl[i].len, tbl[i].mode, 1'b1);
      tick(tbl[i].len > MAXP ? 2 : tbl[i].len + 3);
      chk("t_err", err, tbl[i].exp_err);
      chk("t_tracing_low", tracing, 0);
      chk("t_hold", hold_trace, 1);
      chk("t_busy", busy, 1);
    end
    send_byte(IDLE, 0);
    tick(2);
    chk("t_resume", tracing, 1);
    chk("t_err_sticky", err, 1);

    // reset in the middle of a burst
    do_reset();
    mon_en = 1'b0;
    fill_pl(8'h04, 4, 1'b1);
    send_frame(8'h04, 4, 0, 1'b0);
    tick(1);
    chk("r_in_emit", configId, 8'h04);
    reset = 1'b1;
    #1;
    chk("r_id", configId, IDLE);
    chk("r_tracing", tracing, 1);
    chk("r_busy", busy, 0);
    chk("r_ready", host_ready, 1);
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("r_idle_after", configId, IDLE);
    mon_en = 1'b1;

    // END while tracing is consumed with no effect
    send_byte(IDLE, 0);
    chk("e_tracing", tracing, 1);
    chk("e_hold", hold_trace, 0);
    chk("e_busy", busy, 0);
    chk("e_ready", host_ready, 1);
    tick(3);
    chk("e_still_trace", tracing, 1);

    // random sessions against the frame model
    do_reset();
    for (int s = 0; s < 8; s++) begin
      int nfr;
      if ($urandom_range(0, 3) == 0) send_byte(IDLE, int'($urandom_range(0, 2)));
      nfr = int'($urandom_range(1, 4));
      for (int f = 0; f < nfr; f++) begin
        logic [7:0] id;
        int len, r;
        id = 8'($urandom_range(0, 254));
        r  = int'($urandom_range(0, 9));
        if (r == 0) len = int'($urandom_range(257, 270));
        else if (r == 1) len = 0;
        else if (r == 2) len = MAXP;
        else len = int'($urandom_range(1, 24));
        fill_pl(id, len, 1'b1);
        send_frame(id, len, int'($urandom_range(0, 2)), 1'b1);
      end
      send_byte(IDLE, 0);
      tick(2);
      chk("rnd_tracing", tracing, 1);
      chk("rnd_hold", hold_trace, 0);
      chk("rnd_busy", busy, 0);
      chk("rnd_err", err, exp_err);
    end
    tick(2);
    chk("drained_bytes", exp_dat_q.size(), 0);
    chk("drained_bursts", exp_id_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
